// File: rtl/hfrv_bus_router_if.sv
// hfrv_bus_router_if: CPU port, slave bus and IRQ lines of the router.
// master = router view, slave = CPU/target view.
interface hfrv_bus_router_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  localparam int BEW       = DATA_W / 8,
  localparam int IDW       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
);
  logic [ADDR_W-1:0]            cpu_addr;
  logic [DATA_W-1:0]            cpu_wdata;
  logic [BEW-1:0]               cpu_be;
  logic                         cpu_access;
  logic [DATA_W-1:0]            cpu_rdata;
  logic                         cpu_stall;
  logic                         bus_error;
  logic [ADDR_W-1:0]            err_addr;
  logic [NUM_SLAVES-1:0]        s_req;
  logic [ADDR_W-1:0]            s_addr;
  logic [DATA_W-1:0]            s_wdata;
  logic [BEW-1:0]               s_be;
  logic [NUM_SLAVES-1:0]        s_ack;
  logic [NUM_SLAVES*DATA_W-1:0] s_rdata;
  logic [NUM_SLAVES-1:0]        s_irq;
  logic                         irq;
  logic [IDW-1:0]               irq_id;

  modport master (
    input  cpu_addr, cpu_wdata, cpu_be, cpu_access,
    input  s_ack, s_rdata, s_irq,
    output cpu_rdata, cpu_stall, bus_error, err_addr,
    output s_req, s_addr, s_wdata, s_be,
    output irq, irq_id
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_be, cpu_access,
    output s_ack, s_rdata, s_irq,
    input  cpu_rdata, cpu_stall, bus_error, err_addr,
    input  s_req, s_addr, s_wdata, s_be,
    input  irq, irq_id
  );
endinterface

// File: rtl/hfrv_bus_router.sv
// hfrv_bus_router: base/mask decoded CPU-to-slave router with
// req/ack handshake, timeout bus errors and registered IRQ aggregation.
// Ports: clock, reset (sync, active-high), bus (hfrv_bus_router_if.master).
module hfrv_bus_router #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
    {32'hF0000000, 32'hE2000000, 32'hE1000000, 32'h40000000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK =
    {32'hF0000000, 32'hFF000000, 32'hFF000000, 32'hF0000000},
  parameter int TIMEOUT    = 255
) (
  input logic              clock,
  input logic              reset,
  hfrv_bus_router_if.master bus
);
  localparam int BEW = DATA_W / 8;
  localparam int IDW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, ACCESS, ERROR, DONE
  } state_t;

  state_t                state;
  logic [15:0]           cnt;
  logic [IDW-1:0]        sel_r;
  logic [NUM_SLAVES-1:0] req_r;
  logic [ADDR_W-1:0]     addr_r;
  logic [DATA_W-1:0]     wdata_r;
  logic [BEW-1:0]        be_r;
  logic [DATA_W-1:0]     rdata_r;
  logic                  err_r;
  logic [ADDR_W-1:0]     err_addr_r;
  logic                  irq_r;
  logic [IDW-1:0]        irq_id_r;

  logic                  hit;
  logic [IDW-1:0]        sel_idx;
  logic [IDW-1:0]        irq_idx;
  logic                  ack_sel;
  logic [DATA_W-1:0]     rdata_sel;

  // Walk from the top down so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    sel_idx = '0;
    irq_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((bus.cpu_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) ==
          (SLAVE_BASE[i*ADDR_W +: ADDR_W] &
           SLAVE_MASK[i*ADDR_W +: ADDR_W])) begin
        hit     = 1'b1;
        sel_idx = IDW'(i);
      end
      if (bus.s_irq[i]) irq_idx = IDW'(i);
    end
  end

  assign ack_sel   = bus.s_ack[sel_r];
  assign rdata_sel = bus.s_rdata[int'(sel_r)*DATA_W +: DATA_W];

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      sel_r      <= '0;
      req_r      <= '0;
      addr_r     <= '0;
      wdata_r    <= '0;
      be_r       <= '0;
      rdata_r    <= '0;
      err_r      <= 1'b0;
      err_addr_r <= '0;
      irq_r      <= 1'b0;
      irq_id_r   <= '0;
    end else begin
      irq_r    <= |bus.s_irq;
      irq_id_r <= irq_idx;
      err_r    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cpu_access) begin
            addr_r  <= bus.cpu_addr;
            wdata_r <= bus.cpu_wdata;
            be_r    <= bus.cpu_be;
            sel_r   <= sel_idx;
            cnt     <= '0;
            if (hit) begin
              req_r <= NUM_SLAVES'(1) << sel_idx;
              state <= ACCESS;
            end else begin
              err_r      <= 1'b1;
              err_addr_r <= bus.cpu_addr;
              rdata_r    <= '0;
              state      <= ERROR;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 16'd1;
          // Ack takes priority over a coincident timeout.
          if (ack_sel) begin
            rdata_r <= rdata_sel;
            req_r   <= '0;
            state   <= DONE;
          end else if (cnt == TO_LAST) begin
            req_r      <= '0;
            err_r      <= 1'b1;
            err_addr_r <= addr_r;
            rdata_r    <= '0;
            state      <= ERROR;
          end
        end
        ERROR: state <= DONE;
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall rises in the request cycle so the CPU freezes immediately.
  assign bus.cpu_stall = (state == ACCESS) || (state == ERROR) ||
                         ((state == IDLE) && bus.cpu_access);

  assign bus.cpu_rdata = rdata_r;
  assign bus.bus_error = err_r;
  assign bus.err_addr  = err_addr_r;
  assign bus.s_req     = req_r;
  assign bus.s_addr    = addr_r;
  assign bus.s_wdata   = wdata_r;
  assign bus.s_be      = be_r;
  assign bus.irq       = irq_r;
  assign bus.irq_id    = irq_id_r;
endmodule

// File: tb/tb_hfrv_bus_router.sv
// tb_hfrv_bus_router: directed self-checking bench for hfrv_bus_router.
// Drives at +2 after posedge, samples at +3.
module tb_hfrv_bus_router;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hfrv_bus_router_if #(
    .NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32)
  ) bus ();

  hfrv_bus_router #(
    .NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    #1;
    checks++; if (bus.s_req !== 4'b0) begin failures++; $display("FAIL rst_req got=%h exp=0", bus.s_req); end
    checks++; if (bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", bus.cpu_stall); end
    checks++; if (bus.bus_error !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", bus.bus_error); end
    checks++; if (bus.err_addr !== 32'h0) begin failures++; $display("FAIL rst_erraddr got=%h exp=0", bus.err_addr); end
    checks++; if (bus.cpu_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", bus.cpu_rdata); end
    checks++; if (bus.s_addr !== 32'h0 || bus.s_be !== 4'h0 || bus.s_wdata !== 32'h0) begin failures++; $display("FAIL rst_sbus got=%h/%h/%h exp=0", bus.s_addr, bus.s_be, bus.s_wdata); end
    checks++; if (bus.irq !== 1'b0 || bus.irq_id !== 2'd0) begin failures++; $display("FAIL rst_irq got=%b/%0d exp=0/0", bus.irq, bus.irq_id); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    int stalls;
    bus.cpu_addr = 32'hE2000004;
    bus.cpu_be = 4'b0000;
    bus.cpu_wdata = 32'h0;
    bus.cpu_access = 1'b1;
    #1;
    checks++; if (bus.cpu_stall !== 1'b1) begin failures++; $display("FAIL rd_stall0 got=%b exp=1", bus.cpu_stall); end
    stalls = bus.cpu_stall ? 1 : 0;
    tick();
    bus.cpu_access = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      // Cycle 1 carries a stray ack from slave 0; it must be ignored.
      bus.s_ack = (k == 1) ? 4'b0001 : (k == 3) ? 4'b0100 : 4'b0000;
      #1;
      checks++; if (bus.s_req !== 4'b0100) begin failures++; $display("FAIL rd_req%0d got=%b exp=0100", k, bus.s_req); end
      if (bus.cpu_stall) stalls++;
      tick();
    end
    bus.s_ack = 4'b0;
    #1;
    if (bus.cpu_stall) stalls++;
    checks++; if (bus.cpu_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL rd_data got=%h exp=cafef00d", bus.cpu_rdata); end
    checks++; if (bus.s_req !== 4'b0) begin failures++; $display("FAIL rd_req_done got=%b exp=0", bus.s_req); end
    checks++; if (stalls != 4) begin failures++; $display("FAIL rd_stall_cycles got=%0d exp=4", stalls); end
    tick();
  endtask

  task automatic test_write();
    bus.cpu_addr = 32'h40000010;
    bus.cpu_be = 4'b0011;
    bus.cpu_wdata = 32'hA5A51234;
    bus.cpu_access = 1'b1;
    #1;
    checks++; if (bus.cpu_stall !== 1'b1) begin failures++; $display("FAIL wr_stall0 got=%b exp=1", bus.cpu_stall); end
    tick();
    bus.cpu_access = 1'b0;
    bus.cpu_be = 4'b0;
    bus.cpu_wdata = 32'h0;
    #1;
    checks++; if (bus.s_req !== 4'b0001) begin failures++; $display("FAIL wr_req got=%b exp=0001", bus.s_req); end
    checks++; if (bus.s_be !== 4'b0011) begin failures++; $display("FAIL wr_be got=%b exp=0011", bus.s_be); end
    checks++; if (bus.s_wdata !== 32'hA5A51234) begin failures++; $display("FAIL wr_wdata got=%h exp=a5a51234", bus.s_wdata); end
    checks++; if (bus.s_addr !== 32'h40000010) begin failures++; $display("FAIL wr_addr got=%h exp=40000010", bus.s_addr); end
    checks++; if (bus.cpu_stall !== 1'b1) begin failures++; $display("FAIL wr_stall1 got=%b exp=1", bus.cpu_stall); end
    bus.s_ack = 4'b0001;
    tick();
    bus.s_ack = 4'b0;
    #1;
    checks++; if (bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL wr_stall_done got=%b exp=0", bus.cpu_stall); end
    checks++; if (bus.bus_error !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", bus.bus_error); end
    checks++; if (bus.cpu_rdata !== 32'h11111111) begin failures++; $display("FAIL wr_capture got=%h exp=11111111", bus.cpu_rdata); end
    tick();
  endtask

  task automatic test_unmapped();
    bus.cpu_addr = 32'h80000000;
    bus.cpu_access = 1'b1;
    #1;
    checks++; if (bus.cpu_stall !== 1'b1) begin failures++; $display("FAIL um_stall0 got=%b exp=1", bus.cpu_stall); end
    tick();
    bus.cpu_access = 1'b0;
    #1;
    checks++; if (bus.s_req !== 4'b0) begin failures++; $display("FAIL um_req got=%b exp=0", bus.s_req); end
    checks++; if (bus.bus_error !== 1'b1) begin failures++; $display("FAIL um_err got=%b exp=1", bus.bus_error); end
    checks++; if (bus.err_addr !== 32'h80000000) begin failures++; $display("FAIL um_erraddr got=%h exp=80000000", bus.err_addr); end
    checks++; if (bus.cpu_rdata !== 32'h0) begin failures++; $display("FAIL um_rdata got=%h exp=0", bus.cpu_rdata); end
    checks++; if (bus.cpu_stall !== 1'b1) begin failures++; $display("FAIL um_stall1 got=%b exp=1", bus.cpu_stall); end
    tick();
    #1;
    checks++; if (bus.bus_error !== 1'b0 || bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL um_done got=err%b/stall%b exp=0/0", bus.bus_error, bus.cpu_stall); end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    bus.cpu_addr = 32'hF0000008;
    bus.cpu_access = 1'b1;
    tick();
    bus.cpu_access = 1'b0;
    #1;
    n = 0;
    while (bus.s_req == 4'b1000 && n < 20) begin
      n++;
      if (bus.s_addr !== 32'hF0000008) begin checks++; failures++; $display("FAIL to_addr_hold got=%h exp=f0000008", bus.s_addr); end
      tick();
      #1;
    end
    checks++; if (n != 8) begin failures++; $display("FAIL to_req_cycles got=%0d exp=8", n); end
    checks++; if (bus.bus_error !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", bus.bus_error); end
    checks++; if (bus.err_addr !== 32'hF0000008) begin failures++; $display("FAIL to_erraddr got=%h exp=f0000008", bus.err_addr); end
    checks++; if (bus.cpu_stall !== 1'b1) begin failures++; $display("FAIL to_stall_err got=%b exp=1", bus.cpu_stall); end
    tick();
    #1;
    checks++; if (bus.cpu_stall !== 1'b0 || bus.bus_error !== 1'b0) begin failures++; $display("FAIL to_done got=stall%b/err%b exp=0/0", bus.cpu_stall, bus.bus_error); end
    bus.s_ack = 4'b1000;
    tick();
    tick();
    #1;
    checks++; if (bus.s_req !== 4'b0 || bus.cpu_stall !== 1'b0 || bus.bus_error !== 1'b0) begin failures++; $display("FAIL to_late_ack got=req%b/stall%b/err%b exp=0/0/0", bus.s_req, bus.cpu_stall, bus.bus_error); end
    checks++; if (bus.cpu_rdata !== 32'h0) begin failures++; $display("FAIL to_late_rdata got=%h exp=0", bus.cpu_rdata); end
    bus.s_ack = 4'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bus.cpu_addr = 32'h40000020;
    bus.cpu_be = 4'b0;
    bus.cpu_access = 1'b1;
    tick();
    #1;
    checks++; if (bus.s_req !== 4'b0001) begin failures++; $display("FAIL b2b_req1 got=%b exp=0001", bus.s_req); end
    bus.s_ack = 4'b0001;
    tick();
    bus.s_ack = 4'b0;
    #1;
    checks++; if (bus.cpu_stall !== 1'b0 || bus.s_req !== 4'b0) begin failures++; $display("FAIL b2b_done got=stall%b/req%b exp=0/0", bus.cpu_stall, bus.s_req); end
    tick();
    #1;
    checks++; if (bus.cpu_stall !== 1'b1 || bus.s_req !== 4'b0) begin failures++; $display("FAIL b2b_idle got=stall%b/req%b exp=1/0", bus.cpu_stall, bus.s_req); end
    tick();
    #1;
    checks++; if (bus.s_req !== 4'b0001) begin failures++; $display("FAIL b2b_req2 got=%b exp=0001", bus.s_req); end
    bus.cpu_access = 1'b0;
    bus.s_ack = 4'b0001;
    tick();
    bus.s_ack = 4'b0;
    #1;
    checks++; if (bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", bus.cpu_stall); end
    tick();
  endtask

  task automatic test_irq();
    bus.s_irq = 4'b1010;
    tick();
    #1;
    checks++; if (bus.irq !== 1'b1 || bus.irq_id !== 2'd1) begin failures++; $display("FAIL irq_1010 got=%b/%0d exp=1/1", bus.irq, bus.irq_id); end
    bus.s_irq = 4'b1000;
    tick();
    #1;
    checks++; if (bus.irq !== 1'b1 || bus.irq_id !== 2'd3) begin failures++; $display("FAIL irq_1000 got=%b/%0d exp=1/3", bus.irq, bus.irq_id); end
    bus.s_irq = 4'b0000;
    tick();
    #1;
    checks++; if (bus.irq !== 1'b0 || bus.irq_id !== 2'd0) begin failures++; $display("FAIL irq_none got=%b/%0d exp=0/0", bus.irq, bus.irq_id); end
  endtask

  task automatic test_reset_mid();
    bus.cpu_addr = 32'h40000030;
    bus.cpu_access = 1'b1;
    tick();
    bus.cpu_access = 1'b0;
    #1;
    checks++; if (bus.s_req !== 4'b0001) begin failures++; $display("FAIL rm_req got=%b exp=0001", bus.s_req); end
    rst = 1'b1;
    tick();
    #1;
    checks++; if (bus.s_req !== 4'b0 || bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL rm_after got=req%b/stall%b exp=0/0", bus.s_req, bus.cpu_stall); end
    checks++; if (bus.s_addr !== 32'h0) begin failures++; $display("FAIL rm_saddr got=%h exp=0", bus.s_addr); end
    rst = 1'b0;
    bus.s_ack = 4'b0001;
    tick();
    #1;
    checks++; if (bus.s_req !== 4'b0 || bus.cpu_stall !== 1'b0 || bus.cpu_rdata !== 32'h0) begin failures++; $display("FAIL rm_late_ack got=req%b/stall%b/rd%h exp=0/0/0", bus.s_req, bus.cpu_stall, bus.cpu_rdata); end
    bus.s_ack = 4'b0;
    tick();
  endtask

  initial begin
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    bus.cpu_be = '0;
    bus.cpu_access = 1'b0;
    bus.s_ack = '0;
    bus.s_irq = '0;
    bus.s_rdata = {32'h44444444, 32'hCAFEF00D, 32'h22222222, 32'h11111111};
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_timeout();
    test_back_to_back();
    test_irq();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
